// File: rtl/ram_mfc_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ram_mfc_responder
//  Purpose  : Big-endian byte-addressed RAM answering the MFA/MFC handshake
//             after a fixed access latency. Optional: RAM_ALIGN_CHECK_EN.
//  Revision : 1.0
// ============================================================================
module ram_mfc_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 512
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        MFA,
    input  logic        RW,
    input  logic [1:0]  dataSize,
    input  logic [8:0]  address,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        MFC,
    output logic        busy,
    output logic        alignErr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_LOAD = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_rw;
    logic [1:0]  r_size;
    logic [8:0]  r_addr;
    logic [31:0] r_dataIn;
    logic [31:0] r_dataOut;
    logic        r_mfc;
    logic        r_busy;
    logic        r_alignErr;

    logic [7:0]  r_mem [DEPTH];

    logic [8:0]       w_addr   [4];
    logic [7:0]       w_rdByte [4];
    logic [3:0]       w_we;
    logic [3:0][7:0]  w_wrByte;
    logic [31:0]      w_rdData;
    logic             w_access;
    logic             w_misalign;

    assign w_access = (r_state == S_BUSY) && (r_count == 4'd0);

    // Byte lane g of an access sits at A+g, wrapping around the array.
    for (genvar g = 0; g < 4; g++) begin : g_byteLane
        assign w_addr[g]   = 9'((int'(r_addr) + g) % DEPTH);
        assign w_rdByte[g] = r_mem[w_addr[g]];
    end

`ifdef RAM_ALIGN_CHECK_EN
    assign w_misalign = ((r_size == 2'b01) && r_addr[0]) ||
                        (r_size[1] && (r_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_we     = 4'b0000;
        w_wrByte = '0;
        if (w_access && !r_rw && !w_misalign) begin
            case (r_size)
                2'b00: begin
                    w_we        = 4'b0001;
                    w_wrByte[0] = r_dataIn[7:0];
                end
                2'b01: begin
                    w_we        = 4'b0011;
                    w_wrByte[0] = r_dataIn[15:8];
                    w_wrByte[1] = r_dataIn[7:0];
                end
                default: begin
                    w_we        = 4'b1111;
                    w_wrByte[0] = r_dataIn[31:24];
                    w_wrByte[1] = r_dataIn[23:16];
                    w_wrByte[2] = r_dataIn[15:8];
                    w_wrByte[3] = r_dataIn[7:0];
                end
            endcase
        end
    end

    always_comb begin
        w_rdData = 32'd0;
        if (!w_misalign) begin
            case (r_size)
                2'b00:   w_rdData = {24'd0, w_rdByte[0]};
                2'b01:   w_rdData = {16'd0, w_rdByte[0], w_rdByte[1]};
                default: w_rdData = {w_rdByte[0], w_rdByte[1], w_rdByte[2], w_rdByte[3]};
            endcase
        end
    end

    // Storage has no reset; contents survive a reset pulse.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we[i]) begin
                r_mem[w_addr[i]] <= w_wrByte[i];
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= 4'd0;
            r_rw       <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= 9'd0;
            r_dataIn   <= 32'd0;
            r_dataOut  <= 32'd0;
            r_mfc      <= 1'b0;
            r_busy     <= 1'b0;
            r_alignErr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MFA) begin
                        r_rw     <= RW;
                        r_size   <= dataSize;
                        r_addr   <= address;
                        r_dataIn <= dataIn;
                        r_count  <= c_LOAD;
                        r_busy   <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_count == 4'd0) begin
                        r_mfc      <= 1'b1;
                        r_alignErr <= w_misalign;
                        if (r_rw) begin
                            r_dataOut <= w_rdData;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                S_DONE: begin
                    if (!MFA) begin
                        r_mfc      <= 1'b0;
                        r_alignErr <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dataOut  = r_dataOut;
    assign MFC      = r_mfc;
    assign busy     = r_busy;
    assign alignErr = r_alignErr;

endmodule
`default_nettype wire

// File: tb/tb_ram_mfc_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_mfc_responder
//  Purpose  : Directed self-checking bench for ram_mfc_responder.
//  Revision : 1.0
// ============================================================================
module tb_ram_mfc_responder;

`ifdef RAM_ALIGN_CHECK_EN
    localparam bit c_ALIGN = 1'b1;
`else
    localparam bit c_ALIGN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        MFA = 1'b0;
    logic        RW = 1'b0;
    logic [1:0]  dataSize = 2'b00;
    logic [8:0]  address = 9'd0;
    logic [31:0] dataIn = 32'd0;
    logic [31:0] dataOut;
    logic        MFC;
    logic        busy;
    logic        alignErr;

    int nCompared   = 0;
    int nMismatched = 0;

    ram_mfc_responder #(.LATENCY(2), .DEPTH(512)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .MFA      (MFA),
        .RW       (RW),
        .dataSize (dataSize),
        .address  (address),
        .dataIn   (dataIn),
        .dataOut  (dataOut),
        .MFC      (MFC),
        .busy     (busy),
        .alignErr (alignErr)
    );

    always #5 Clk = ~Clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One full handshake; inputs are scrambled right after capture to prove latching.
    task automatic memOp(input string tag, input logic rw, input logic [1:0] size,
                         input logic [8:0] addr, input logic [31:0] din, input int hold,
                         output logic [31:0] rd, output logic ae, output int edges);
        @(negedge Clk);
        MFA = 1'b1; RW = rw; dataSize = size; address = addr; dataIn = din;
        @(posedge Clk); #1;
        checkValue({tag, " busy"}, 32'(busy), 32'd1);
        RW = ~rw; dataSize = ~size; address = addr + 9'd5; dataIn = ~din;
        edges = 0;
        while (!MFC && edges < 20) begin
            @(posedge Clk); #1;
            edges++;
        end
        checkValue({tag, " mfc"}, 32'(MFC), 32'd1);
        rd = dataOut;
        ae = alignErr;
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            checkValue({tag, " hold mfc"}, 32'(MFC), 32'd1);
            checkValue({tag, " hold data"}, dataOut, rd);
        end
        @(negedge Clk);
        MFA = 1'b0;
        @(posedge Clk); #1;
        checkValue({tag, " release mfc"}, 32'(MFC), 32'd0);
        checkValue({tag, " release busy"}, 32'(busy), 32'd0);
    endtask

    logic [31:0] rd;
    logic        ae;
    int          edges;
    bit          sawMfc;

    initial begin
        // Reset and idle
        repeat (2) @(negedge Clk);
        reset = 1'b0;
        #1;
        checkValue("reset mfc", 32'(MFC), 32'd0);
        checkValue("reset busy", 32'(busy), 32'd0);
        checkValue("reset dataOut", dataOut, 32'd0);
        checkValue("reset alignErr", 32'(alignErr), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            checkValue("idle mfc", 32'(MFC), 32'd0);
            checkValue("idle busy", 32'(busy), 32'd0);
        end

        // Word write / reads at address 8
        memOp("wr8", 1'b0, 2'b10, 9'd8, 32'hDEADBEEF, 0, rd, ae, edges);
        checkValue("wr8 latency", 32'(edges), 32'd2);
        checkValue("wr8 dataOut kept", dataOut, 32'd0);
        memOp("rd8", 1'b1, 2'b10, 9'd8, 32'd0, 0, rd, ae, edges);
        checkValue("rd8 data", rd, 32'hDEADBEEF);
        checkValue("rd8 latency", 32'(edges), 32'd2);
        memOp("rd9b", 1'b1, 2'b00, 9'd9, 32'd0, 0, rd, ae, edges);
        checkValue("rd9 byte", rd, 32'h000000AD);
        memOp("rd8s3", 1'b1, 2'b11, 9'd8, 32'd0, 0, rd, ae, edges);
        checkValue("rd8 size11", rd, 32'hDEADBEEF);

        // Merge of word, halfword and byte writes, then a held read
        memOp("wr16", 1'b0, 2'b10, 9'd16, 32'h11223344, 0, rd, ae, edges);
        memOp("wr18h", 1'b0, 2'b01, 9'd18, 32'h0000AABB, 0, rd, ae, edges);
        memOp("wr16b", 1'b0, 2'b00, 9'd16, 32'h000000CC, 0, rd, ae, edges);
        memOp("rd16", 1'b1, 2'b10, 9'd16, 32'd0, 5, rd, ae, edges);
        checkValue("rd16 merged", rd, 32'hCC22AABB);
        memOp("rd17b", 1'b1, 2'b00, 9'd17, 32'd0, 0, rd, ae, edges);
        checkValue("rd17 byte", rd, 32'h00000022);
        checkValue("rd17 next-capture latency", 32'(edges), 32'd2);

        // Wrap-around at the top of the array
        memOp("wr510", 1'b0, 2'b10, 9'd510, 32'h01020304, 0, rd, ae, edges);
        checkValue("wr510 alignErr", 32'(ae), c_ALIGN ? 32'd1 : 32'd0);
`ifndef RAM_ALIGN_CHECK_EN
        memOp("rd510", 1'b1, 2'b00, 9'd510, 32'd0, 0, rd, ae, edges);
        checkValue("mem510", rd, 32'h00000001);
        memOp("rd511", 1'b1, 2'b00, 9'd511, 32'd0, 0, rd, ae, edges);
        checkValue("mem511", rd, 32'h00000002);
        memOp("rd0", 1'b1, 2'b00, 9'd0, 32'd0, 0, rd, ae, edges);
        checkValue("mem0", rd, 32'h00000003);
        memOp("rd1", 1'b1, 2'b00, 9'd1, 32'd0, 0, rd, ae, edges);
        checkValue("mem1", rd, 32'h00000004);
        memOp("rd0h", 1'b1, 2'b01, 9'd0, 32'd0, 0, rd, ae, edges);
        checkValue("rd0 half", rd, 32'h00000304);
`endif

        // Reset while a write is in flight
        memOp("wr32", 1'b0, 2'b10, 9'd32, 32'h55667788, 0, rd, ae, edges);
        @(negedge Clk);
        MFA = 1'b1; RW = 1'b0; dataSize = 2'b10; address = 9'd32; dataIn = 32'hFFFFFFFF;
        @(posedge Clk); #1;
        MFA = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        sawMfc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (MFC) sawMfc = 1'b1;
        end
        checkValue("abort mfc", 32'(sawMfc), 32'd0);
        checkValue("abort busy", 32'(busy), 32'd0);
        memOp("rd32", 1'b1, 2'b10, 9'd32, 32'd0, 0, rd, ae, edges);
        checkValue("rd32 after abort", rd, 32'h55667788);

        // Misaligned word write at address 6
        memOp("wr4", 1'b0, 2'b10, 9'd4, 32'h0A0B0C0D, 0, rd, ae, edges);
        memOp("wr6", 1'b0, 2'b10, 9'd6, 32'h99999999, 0, rd, ae, edges);
        checkValue("wr6 alignErr", 32'(ae), c_ALIGN ? 32'd1 : 32'd0);
        checkValue("wr6 alignErr cleared", 32'(alignErr), 32'd0);
        memOp("rd4", 1'b1, 2'b10, 9'd4, 32'd0, 0, rd, ae, edges);
        checkValue("rd4 after wr6", rd, c_ALIGN ? 32'h0A0B0C0D : 32'h0A0B9999);
        memOp("rd8b", 1'b1, 2'b10, 9'd8, 32'd0, 0, rd, ae, edges);
        checkValue("rd8 after wr6", rd, c_ALIGN ? 32'hDEADBEEF : 32'h9999BEEF);
        memOp("rd6", 1'b1, 2'b10, 9'd6, 32'd0, 0, rd, ae, edges);
        checkValue("rd6 data", rd, c_ALIGN ? 32'h00000000 : 32'h99999999);
        checkValue("rd6 alignErr", 32'(ae), c_ALIGN ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_mfc_responder.md
Name: ram_mfc_responder

Overview:
Byte-addressed 512-byte data/instruction RAM that answers the control unit's MFA/MFC memory handshake. It latches a request when MFA is high, waits a fixed access latency, performs the read or write, and then raises MFC until the initiator drops MFA. It sits between the control unit and the MAR/MDR datapath registers. It is the responder end of the ramMFA/ramRW/ramDataSize/ramAddress interface.

Parameters:
LATENCY, 2, rising edges from request capture to MFC assertion (legal range 1..15)
DEPTH, 512, bytes of storage; address space is 0..DEPTH-1

Ports:
Clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
MFA  input  1  memory function active (request strobe from the control unit)
RW  input  1  1 = read, 0 = write
dataSize  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
address  input  9  byte address of the most significant byte
dataIn  input  32  write data; byte uses [7:0], halfword uses [15:0], word uses [31:0]
dataOut  output  32  registered read data, zero-extended
MFC  output  1  memory function complete
busy  output  1  high in BUSY and DONE
alignErr  output  1  misalignment flag, valid with MFC (see Optional Feature)

Behaviour:
- Reset (async, active-high):
  - state = IDLE; MFC = 0, busy = 0, dataOut = 0, alignErr = 0, wait counter = 0.
  - Memory array is NOT cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On a rising edge with MFA = 1: capture RW, dataSize, address and dataIn.
  - Load counter with LATENCY-1 and go to BUSY.
  - Inputs that change after the capture edge are ignored.
- BUSY:
  - Counter decrements each edge.
  - On the edge where the counter is 0, perform the access, set MFC = 1 and go to DONE.
  - MFC therefore rises on the LATENCY-th edge after the capture edge.
  - If MFA drops during BUSY, the access still completes; DONE is then exited on the next edge.
- DONE:
  - MFC and dataOut are held while MFA = 1.
  - On the first edge with MFA = 0: MFC = 0, go to IDLE.
  - A new request can be captured on the edge after that; there is no back-to-back capture from DONE.
- Byte ordering (big-endian):
  - Byte at address A is most significant.
  - Word read: dataOut = {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
  - Halfword read: dataOut = {16'b0, mem[A], mem[A+1]}.
  - Byte read: dataOut = {24'b0, mem[A]}.
  - Writes store the corresponding low-order bytes of dataIn in the same order.
- Address arithmetic: A+i wraps modulo DEPTH (511+1 = 0).
- dataOut behaviour:
  - Updated only on read completion.
  - Unchanged by writes.
  - Holds its last value in IDLE.
- Reset during BUSY: a pending write is discarded with memory unchanged, and MFC never asserts.
- dataSize = 11 behaves exactly as a word access.

Optional Feature:
RAM_ALIGN_CHECK_EN
- Defined:
  - A halfword at an odd address, or a word at an address not divisible by 4, is misaligned.
  - The handshake completes normally with MFC = 1 and alignErr = 1.
  - A misaligned write does not modify memory.
  - A misaligned read returns dataOut = 0.
  - alignErr clears with MFC.
- Undefined:
  - alignErr is tied to 0.
  - Misaligned accesses proceed with wrap-around byte addressing as described above.

Test Plan:
- Reset then idle: reset pulse at t=0 with MFA = 0 -> MFC = 0, busy = 0, dataOut = 0 and no state change for 10 cycles.
- Word write then word read with LATENCY = 2:
  - Write 0xDEADBEEF to address 8 -> MFC rises exactly 2 edges after capture.
  - Read of address 8 -> dataOut = 0xDEADBEEF.
  - Byte read of address 9 -> 0x000000AD.
- Halfword/byte write merge:
  - Word write 0x11223344 to address 16, halfword write 0xAABB to address 18, byte write 0xCC to address 16.
  - Word read of address 16 -> 0xCC22AABB.
- Handshake hold and release:
  - Hold MFA high 5 cycles after MFC -> MFC and dataOut stay stable.
  - Drop MFA -> MFC = 0 on the next edge, and a new MFA is captured on the following edge.
- Wrap-around:
  - Word write 0x01020304 to address 510 -> mem[510] = 01, mem[511] = 02, mem[0] = 03, mem[1] = 04.
  - Halfword read of address 0 -> 0x00000304.
- Reset mid-operation and alignment:
  - Word write 0xFFFFFFFF to address 32 with reset asserted in BUSY -> MFC never rises and a later read of address 32 returns the prior contents.
  - With RAM_ALIGN_CHECK_EN, word write to address 6 -> alignErr = 1 with MFC and memory at 6..9 unchanged.
